// File: rtl/iob_mem_responder.sv
// Simple-bus memory responder: accepts one request at a time, waits a
// configurable number of cycles, then answers with a single ready pulse.
// Storage is a byte-writable single-port synchronous RAM. The RAM is read
// or written once per transaction, on the edge that raises ready.
module iob_mem_responder #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int MEM_ADDR_W = 10,
  parameter int WAIT       = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic                err,
  output logic                overrun
);

  localparam int         STRB_W    = DATA_W / 8;
  localparam int         WADDR_W   = ADDR_W - 2;
  localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic [WADDR_W-1:0]  lat_waddr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [STRB_W-1:0]   lat_wstrb;

  logic [DATA_W-1:0]   mem [0:(1 << MEM_ADDR_W) - 1];
  logic [DATA_W-1:0]   mem_q;
  logic                rd_ok;

  logic                accept;
  logic                go_resp;
  logic [WADDR_W-1:0]  op_waddr;
  logic [DATA_W-1:0]   op_wdata;
  logic [STRB_W-1:0]   op_wstrb;
  logic [MEM_ADDR_W-1:0] op_idx;
  logic                op_oor;
  logic                op_read;

  // Byte offset within the word plays no part in addressing.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^address[1:0];

  // Select the operand set for the edge that raises ready: the latched
  // request when leaving WAIT, or the live inputs when WAIT is zero and the
  // request goes straight to RESP.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    op_waddr = address[ADDR_W-1:2];
    op_wdata = wdata;
    op_wstrb = wstrb;
    if (state == ST_WAIT) begin
      op_waddr = lat_waddr;
      op_wdata = lat_wdata;
      op_wstrb = lat_wstrb;
    end
    op_idx  = op_waddr[MEM_ADDR_W-1:0];
    op_oor  = (op_waddr >> MEM_ADDR_W) != '0;
    op_read = (op_wstrb == '0);
    accept  = resetn && valid && (state != ST_WAIT);
    go_resp = (state == ST_WAIT && cnt == 4'd0) || (WAIT == 0 && accept);
  end

  // Request FSM with registered ready/err pulses and sticky overrun.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      ready     <= 1'b0;
      err       <= 1'b0;
      overrun   <= 1'b0;
      rd_ok     <= 1'b0;
      lat_waddr <= '0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values; the defaults below make ready and
      // err single-cycle pulses.
      ready <= 1'b0;
      err   <= 1'b0;
      if (go_resp) begin
        ready <= 1'b1;
        err   <= op_oor;
        rd_ok <= !op_oor && op_read;
      end
      case (state)
        ST_IDLE, ST_RESP: begin
          if (valid) begin
            lat_waddr <= address[ADDR_W-1:2];
            lat_wdata <= wdata;
            lat_wstrb <= wstrb;
            if (WAIT > 0) begin
              state <= ST_WAIT;
              cnt   <= WAIT_LOAD;
            end else begin
              state <= ST_RESP;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (valid) overrun <= 1'b1;
          if (cnt == 4'd0) state <= ST_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Single-port RAM: one byte-masked write or one registered read per
  // response; out-of-range requests never touch the array.
  always_ff @(posedge clk) begin
    // NOTE: the storage array and its read register are deliberately not
    // reset so the array maps onto block RAM; rd_ok masks mem_q until a
    // valid read has loaded it.
    if (go_resp && !op_oor) begin
      if (op_read) begin
        mem_q <= mem[op_idx];
      end else begin
        for (int i = 0; i < STRB_W; i++) begin
          if (op_wstrb[i]) mem[op_idx][i*8 +: 8] <= op_wdata[i*8 +: 8];
        end
      end
    end
  end

  // Write and error responses return zero; rdata holds between responses
  // because both mem_q and rd_ok change only on a response edge.
  assign rdata = mem_q & {DATA_W{rd_ok}};

endmodule

// File: tb/tb_iob_mem_responder.sv
// Directed bench for iob_mem_responder: three instances with WAIT = 0, 1
// and 3 share one clock; inputs are driven and outputs sampled on the
// falling edge.
module tb_iob_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  resetn, valid, ready, err, overrun;
  logic [31:0] address [3];
  logic [31:0] wdata   [3];
  logic [31:0] rdata   [3];
  logic [3:0]  wstrb   [3];

  // Instance 0: WAIT=0, instance 1: WAIT=1, instance 2: WAIT=3.
  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      iob_mem_responder #(
        .DATA_W(32), .ADDR_W(32), .MEM_ADDR_W(10),
        .WAIT((g == 0) ? 0 : ((g == 1) ? 1 : 3))
      ) u_dut (
        .clk(clk), .resetn(resetn[g]), .valid(valid[g]),
        .address(address[g]), .wdata(wdata[g]), .wstrb(wstrb[g]),
        .rdata(rdata[g]), .ready(ready[g]), .err(err[g]),
        .overrun(overrun[g])
      );
    end
  endgenerate

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request starting at the current falling edge; return the
  // number of falling edges until ready (0 = no response within budget).
  task automatic do_req(input int k, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd, output logic e,
                        output int lat);
    valid[k] = 1'b1; address[k] = a; wdata[k] = d; wstrb[k] = s;
    lat = 0; rd = '0; e = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      valid[k] = 1'b0;
      if (ready[k]) begin
        lat = n; rd = rdata[k]; e = err[k];
        break;
      end
    end
  endtask

  task automatic count_ready(input int k, input int ncyc, output int cnt);
    cnt = 0;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      if (ready[k]) cnt++;
    end
  endtask

  logic [31:0] rd;
  logic        e;
  int          lat;
  int          nrdy;

  initial begin
    resetn = '0;
    valid  = '0;
    for (int k = 0; k < 3; k++) begin
      address[k] = '0; wdata[k] = '0; wstrb[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_ready%0d", k),   32'(ready[k]),   32'd0);
      check($sformatf("rst_err%0d", k),     32'(err[k]),     32'd0);
      check($sformatf("rst_overrun%0d", k), 32'(overrun[k]), 32'd0);
      check($sformatf("rst_rdata%0d", k),   rdata[k],        32'd0);
    end

    // ---- WAIT=1: request issued in the first cycle after release ----
    resetn[1] = 1'b1;
    do_req(1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat);
    check("w1_wr_lat", lat, 32'd2);
    check("w1_wr_rdata", rd, 32'd0);
    check("w1_wr_err", 32'(e), 32'd0);
    do_req(1, 32'h10, 32'h0, 4'h0, rd, e, lat);
    check("w1_rd_lat", lat, 32'd2);
    check("w1_rd_data", rd, 32'hDEADBEEF);
    check("w1_rd_err", 32'(e), 32'd0);

    // Partial write preserves untouched bytes.
    do_req(1, 32'h20, 32'h11223344, 4'hF, rd, e, lat);
    do_req(1, 32'h20, 32'h0000AA00, 4'h2, rd, e, lat);
    check("w1_pw_lat", lat, 32'd2);
    do_req(1, 32'h20, 32'h0, 4'h0, rd, e, lat);
    check("w1_pw_data", rd, 32'h1122AA44);
    repeat (3) @(negedge clk);
    check("w1_hold_ready", 32'(ready[1]), 32'd0);
    check("w1_hold_rdata", rdata[1], 32'h1122AA44);
    do_req(1, 32'h21, 32'h0, 4'h0, rd, e, lat);
    check("w1_lsb_ignored", rd, 32'h1122AA44);

    // Out-of-range read and write; word 0 aliases 0x1000 in the low bits.
    do_req(1, 32'h0, 32'h55667788, 4'hF, rd, e, lat);
    do_req(1, 32'h1000, 32'h0, 4'h0, rd, e, lat);
    check("w1_oor_rd_lat", lat, 32'd2);
    check("w1_oor_rd_err", 32'(e), 32'd1);
    check("w1_oor_rd_data", rd, 32'd0);
    @(negedge clk);
    check("w1_err_pulse", 32'(err[1]), 32'd0);
    do_req(1, 32'h1000, 32'hFFFFFFFF, 4'hF, rd, e, lat);
    check("w1_oor_wr_err", 32'(e), 32'd1);
    do_req(1, 32'h0, 32'h0, 4'h0, rd, e, lat);
    check("w1_word0_kept", rd, 32'h55667788);
    check("w1_word0_err", 32'(e), 32'd0);
    check("w1_overrun", 32'(overrun[1]), 32'd0);

    // ---- WAIT=0: back-to-back requests issued in each ready cycle ----
    resetn[0] = 1'b1;
    @(negedge clk);
    do_req(0, 32'h10, 32'hCAFEF00D, 4'hF, rd, e, lat);
    check("w0_wr_lat", lat, 32'd1);
    do_req(0, 32'h20, 32'h0BADC0DE, 4'hF, rd, e, lat);
    check("w0_wr2_lat", lat, 32'd1);
    valid[0] = 1'b1; address[0] = 32'h10; wstrb[0] = 4'h0;
    @(negedge clk);
    check("w0_b2b1_ready", 32'(ready[0]), 32'd1);
    check("w0_b2b1_data", rdata[0], 32'hCAFEF00D);
    address[0] = 32'h20;
    @(negedge clk);
    check("w0_b2b2_ready", 32'(ready[0]), 32'd1);
    check("w0_b2b2_data", rdata[0], 32'h0BADC0DE);
    address[0] = 32'h30; wdata[0] = 32'h12345678; wstrb[0] = 4'hF;
    @(negedge clk);
    check("w0_b2b3_ready", 32'(ready[0]), 32'd1);
    check("w0_b2b3_data", rdata[0], 32'd0);
    wstrb[0] = 4'h0;
    @(negedge clk);
    check("w0_raw_ready", 32'(ready[0]), 32'd1);
    check("w0_raw_data", rdata[0], 32'h12345678);
    valid[0] = 1'b0;
    @(negedge clk);
    check("w0_idle_ready", 32'(ready[0]), 32'd0);
    check("w0_overrun", 32'(overrun[0]), 32'd0);

    // ---- WAIT=3: second valid while waiting is dropped ----
    resetn[2] = 1'b1;
    @(negedge clk);
    do_req(2, 32'h40, 32'hAABBCCDD, 4'hF, rd, e, lat);
    check("w3_wr_lat", lat, 32'd4);
    valid[2] = 1'b1; address[2] = 32'h40; wstrb[2] = 4'h0;
    @(negedge clk);
    address[2] = 32'h44;
    @(negedge clk);
    valid[2] = 1'b0;
    count_ready(2, 10, nrdy);
    check("w3_single_ready", nrdy, 32'd1);
    check("w3_overrun_set", 32'(overrun[2]), 32'd1);
    repeat (5) @(negedge clk);
    check("w3_overrun_sticky", 32'(overrun[2]), 32'd1);

    // Reset while waiting: request dropped, overrun cleared.
    valid[2] = 1'b1; address[2] = 32'h40; wstrb[2] = 4'h0;
    @(negedge clk);
    valid[2] = 1'b0;
    resetn[2] = 1'b0;
    @(negedge clk);
    check("w3_rst_overrun", 32'(overrun[2]), 32'd0);
    check("w3_rst_ready", 32'(ready[2]), 32'd0);
    resetn[2] = 1'b1;
    count_ready(2, 8, nrdy);
    check("w3_no_ready_after_rst", nrdy, 32'd0);
    check("w3_overrun_after_rst", 32'(overrun[2]), 32'd0);
    do_req(2, 32'h44, 32'h0F0F0F0F, 4'hF, rd, e, lat);
    check("w3_post_wr_lat", lat, 32'd4);
    do_req(2, 32'h44, 32'h0, 4'h0, rd, e, lat);
    check("w3_post_rd_lat", lat, 32'd4);
    check("w3_post_rd_data", rd, 32'h0F0F0F0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
